// File: rtl/midi_pkg.sv
// Shared constants, state encodings and helpers for the MIDI transmit path.
// Imported by the byte serialiser and the message sequencer.
package midi_pkg;

  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [7:0] STATUS_NONE   = 8'h00;

  // Message byte positions; a running-status message starts at IDX_KEY.
  localparam logic [1:0] IDX_STATUS = 2'd0;
  localparam logic [1:0] IDX_KEY    = 2'd1;
  localparam logic [1:0] IDX_VEL    = 2'd2;

  // Message sequencer states.
  localparam logic [0:0] SEQ_IDLE = 1'b0;
  localparam logic [0:0] SEQ_SEND = 1'b1;

  // Byte serialiser states.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [7:0] note_status(input logic note_on, input logic [3:0] channel);
    return {(note_on ? MIDI_NOTE_ON : MIDI_NOTE_OFF), channel};
  endfunction

  function automatic int div_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser: start bit, eight data bits LSB first, stop bit,
// each lasting div_last+1 clocks. A start seen at the end of a stop bit chains the next byte with no gap.
module uart_byte_tx
  import midi_pkg::*;
#(
  parameter int DIV_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       data,
  input  logic [DIV_W-1:0] div_last,
  output logic             sout,
  output logic             done
);

  tx_state_e        state_r;
  logic [DIV_W-1:0] cnt_r;
  logic [2:0]       bit_r;
  logic [7:0]       shift_r;
  logic             sout_r;
  logic             tc_s;

  assign tc_s = (cnt_r == div_last);
  // done is a same-cycle strobe so the sequencer can present the next byte on the very edge the stop bit ends.
  assign done = (state_r == TX_STOP) && tc_s;
  assign sout = sout_r;

  // Line state machine with per-bit baud counter reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= TX_IDLE;
      cnt_r   <= {DIV_W{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      sout_r  <= 1'b1;
    end else begin
      case (state_r)
        TX_IDLE: begin
          if (start) begin
            state_r <= TX_START;
            cnt_r   <= {DIV_W{1'b0}};
            shift_r <= data;
            sout_r  <= 1'b0;
          end
        end
        TX_START: begin
          if (tc_s) begin
            state_r <= TX_DATA;
            cnt_r   <= {DIV_W{1'b0}};
            bit_r   <= 3'd0;
            sout_r  <= shift_r[0];
            shift_r <= {1'b0, shift_r[7:1]};
          end else begin
            cnt_r <= cnt_r + DIV_W'(1);
          end
        end
        TX_DATA: begin
          if (tc_s) begin
            cnt_r <= {DIV_W{1'b0}};
            if (bit_r == 3'd7) begin
              state_r <= TX_STOP;
              sout_r  <= 1'b1;
            end else begin
              bit_r   <= bit_r + 3'd1;
              sout_r  <= shift_r[0];
              shift_r <= {1'b0, shift_r[7:1]};
            end
          end else begin
            cnt_r <= cnt_r + DIV_W'(1);
          end
        end
        TX_STOP: begin
          if (tc_s) begin
            cnt_r <= {DIV_W{1'b0}};
            if (start) begin
              state_r <= TX_START;
              shift_r <= data;
              sout_r  <= 1'b0;
            end else begin
              state_r <= TX_IDLE;
              sout_r  <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + DIV_W'(1);
          end
        end
        default: begin
          state_r <= TX_IDLE;
          cnt_r   <= {DIV_W{1'b0}};
          sout_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/midi_tx.sv
// MIDI OUT transmitter: accepts note events, formats Note On/Off messages
// with optional running status, and serialises them as 8N1 UART.
module midi_tx
  import midi_pkg::*;
#(
  parameter int CLOCK_FREQ     = 100000000,
  parameter int BAUD_RATE      = 31250,
  parameter int RUNNING_STATUS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic       ev_note_on,
  input  logic [3:0] ev_channel,
  input  logic [6:0] ev_key,
  input  logic [6:0] ev_velocity,
  output logic       sout,
  output logic       busy
);

  localparam int               DIV      = CLOCK_FREQ / BAUD_RATE;
  localparam int               DIV_W    = div_width(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic             RS_EN    = (RUNNING_STATUS != 0);

  logic [0:0] seq_r;
  logic       ev_ready_r;
  logic       busy_r;
  logic       start_r;
  logic [1:0] idx_r;
  logic [7:0] cache_r;
  logic [7:0] status_r;
  logic [7:0] key_r;
  logic [7:0] vel_r;

  logic       accept_s;
  logic       skip_s;
  logic       more_s;
  logic       tx_start_s;
  logic       tx_done_s;
  logic [1:0] tx_idx_s;
  logic [7:0] ev_status_s;
  logic [7:0] tx_data_s;

  // Handshake, running-status decision and next-byte selection.
  always_comb begin
    accept_s    = ev_valid && ev_ready_r;
    ev_status_s = note_status(ev_note_on, ev_channel);
    skip_s      = RS_EN && (ev_status_s == cache_r);
    more_s      = (idx_r != IDX_VEL);
    tx_start_s  = start_r || (tx_done_s && more_s && (seq_r == SEQ_SEND));
    // The first byte of a message is idx_r itself; chained bytes are the one after it.
    tx_idx_s    = start_r ? idx_r : (idx_r + 2'd1);
    case (tx_idx_s)
      IDX_STATUS: tx_data_s = status_r;
      IDX_KEY:    tx_data_s = key_r;
      IDX_VEL:    tx_data_s = vel_r;
      default:    tx_data_s = 8'h00;
    endcase
  end

  // Message sequencer: capture, byte index, status cache and ready/busy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_r      <= SEQ_IDLE;
      ev_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      start_r    <= 1'b0;
      idx_r      <= IDX_STATUS;
      cache_r    <= STATUS_NONE;
      status_r   <= 8'h00;
      key_r      <= 8'h00;
      vel_r      <= 8'h00;
    end else begin
      start_r <= accept_s;
      case (seq_r)
        SEQ_IDLE: begin
          if (accept_s) begin
            seq_r      <= SEQ_SEND;
            ev_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            status_r   <= ev_status_s;
            key_r      <= {1'b0, ev_key};
            vel_r      <= {1'b0, ev_velocity};
            idx_r      <= skip_s ? IDX_KEY : IDX_STATUS;
          end
        end
        SEQ_SEND: begin
          if (tx_done_s) begin
            if (idx_r == IDX_STATUS) begin
              cache_r <= status_r;
            end
            if (more_s) begin
              idx_r <= idx_r + 2'd1;
            end else begin
              seq_r      <= SEQ_IDLE;
              ev_ready_r <= 1'b1;
              busy_r     <= 1'b0;
              idx_r      <= IDX_STATUS;
            end
          end
        end
        default: begin
          seq_r      <= SEQ_IDLE;
          ev_ready_r <= 1'b1;
          busy_r     <= 1'b0;
          idx_r      <= IDX_STATUS;
        end
      endcase
    end
  end

  uart_byte_tx #(
    .DIV_W(DIV_W)
  ) u_byte_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (tx_start_s),
    .data    (tx_data_s),
    .div_last(DIV_LAST),
    .sout    (sout),
    .done    (tx_done_s)
  );

  assign ev_ready = ev_ready_r;
  assign busy     = busy_r;

endmodule
